inst_encoder: RTL and testbench
===============================

# inst_encoder

Packs decoded RISC instruction fields back into 32-bit instruction words and streams them, in order, to the instruction-memory write port with an auto-incrementing address. It is the write-side counterpart of the instruction decoder: a word produced here decodes back to the same fields. It is used by the program loader and test infrastructure to fill instruction memory. A small FIFO decouples field producers from memory write back-pressure.

## Interface

- DEPTH, 4, FIFO depth in words; power of 2, at least 2.
- AW, 8, instruction-memory address width.
- BASE, 0, first write address after reset or clear.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: empties the FIFO, reloads the address to BASE, clears wrap.
- in_valid  in  1  field set is valid.
- in_ready  out  1  encoder can accept a field set.
- opcode  in  6  opcode field.
- rd  in  5  destination register.
- rs  in  5  source register.
- rt  in  5  operand register.
- shift  in  5  shift amount.
- func  in  6  function field.
- out_valid  out  1  wr_data/wr_addr hold a pending word.
- out_ready  in  1  memory accepts the word this cycle.
- wr_data  out  32  packed instruction word.
- wr_addr  out  AW  target address of wr_data.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- wrap  out  1  sticky flag: the address has rolled over.

## Operation

- Packing: {opcode, rd, rs, rt, shift, func}, with opcode in [31:26], rd in [25:21], rs in [20:16], rt in [15:11], shift in [10:6] and func in [5:0]. Packing is pure concatenation, with no field checks.
- Push condition: in_valid && in_ready. The packed word is written at the write pointer.
- Pop condition: out_valid && out_ready. The read pointer advances and wr_addr increments by 1.
- in_ready = (count != DEPTH). This is combinational from registered state only and never depends on out_ready. There is no pass-through when full.
- out_valid = (count != 0).
- wr_data is the FIFO head and wr_addr is the address register. Both are held stable while out_valid && !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. count is updated as follows:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Address arithmetic is modulo 2^AW. A pop at address 2^AW-1 gives next address 0 and sets wrap. wrap stays set until reset or clear.
- clear has priority over push and pop in the same cycle. That cycle's input is dropped and no write is acknowledged to the memory side.
- Reset values: count=0, out_valid=0, in_ready=1, wr_addr=BASE, wrap=0, wr_data=0. FIFO storage contents are don't-care.
- Reset mid-operation takes effect immediately (asynchronous). All queued words are discarded.

## Timing

- Latency: a field set accepted at edge N appears on wr_data with out_valid=1 after edge N.
- Throughput: one word per cycle when in_valid and out_ready are both held high.
- Full: with count=DEPTH, in_ready=0. A simultaneous pop in that cycle raises in_ready in the following cycle.
- Empty: with count=0, out_valid=0 and out_ready is ignored. wr_addr does not change.
- Simultaneous push and pop at count=1: the head is replaced by the new word after the edge and count stays 1.
- in_valid with in_ready=0: nothing is accepted, and the producer must hold its fields.
- Deassertion of rst_n is synchronized by the environment. The first push may occur on the first edge after release.

## Test plan

- Reset, then push opcode=1, rd=2, rs=3, rt=4, shift=0, func=0x20 with out_ready=1 -> the next cycle shows wr_data=0x04432020, wr_addr=0, out_valid=1; after the pop, wr_addr=1 and count=0.
- Round trip: push shift=1, func=61, all other fields 0 -> wr_data=32'd125. Feed it to the instruction decoder -> shift=1, func=61 are recovered. Repeat for 132, 264, 143 and 279.
- Back-pressure: out_ready=0, push 5 sets with DEPTH=4 -> in_ready falls after the 4th push and count=4. The 5th set is held, not lost. Raise out_ready -> words drain in order to addresses 0..3, then the 5th word goes to address 4.
- Wrap: AW=2, push 5 words with out_ready=1 -> addresses 0, 1, 2, 3, 0; wrap rises on the pop at address 3 and stays high.
- clear with push and pop asserted and count=2 -> the next cycle shows count=0, out_valid=0, wr_addr=BASE, wrap=0, and the input word is not stored.
- rst_n pulsed low mid-burst with count=3 -> outputs take their reset values asynchronously, and no write is presented after release until a new push.

Source files
------------

// File: rtl/inst_encoder.sv
// Purpose: packs decoded instruction fields into 32-bit words and streams them to instruction memory at auto-incrementing addresses.
// Latency: a field set accepted at edge N is presented on wr_data/wr_addr right after edge N.
// Backpressure: a DEPTH-entry FIFO absorbs memory stalls; in_ready drops only when the FIFO is full (no pass-through when full).
module inst_encoder #(
   parameter int            DEPTH = 4,
   parameter int            AW    = 8,
   parameter logic [AW-1:0] BASE  = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [5:0]               opcode,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs,
   input  logic [4:0]               rt,
   input  logic [4:0]               shift,
   input  logic [5:0]               func,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              wr_data,
   output logic [AW-1:0]            wr_addr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     wrap
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   word;
   logic          push;
   logic          pop;

   // Field layout mirrors the decoder: opcode high, func low, no field validation.
   assign word = {opcode, rd, rs, rt, shift, func};

   // Handshake terms depend only on registered occupancy, so in_ready never follows out_ready.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head is forced to zero while empty so the port shows a clean value after reset.
   assign wr_data = out_valid ? mem[rd_ptr] : '0;

   // Storage write; contents need no reset because occupancy gates visibility. A clear cycle drops the input.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= word;
      end
   end

   // Pointers, occupancy, address and sticky wrap; clear outranks push and pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         wr_addr <= BASE;
         wrap    <= 1'b0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         wr_addr <= BASE;
         wrap    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            wr_addr <= wr_addr + 1'b1;
            if (wr_addr == '1) begin
               wrap <= 1'b1;
            end
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

   localparam int DEPTH = 4;
   localparam int AW    = 8;
   localparam int AMOD  = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [5:0]  opcode = '0;
   logic [4:0]  rd = '0;
   logic [4:0]  rs = '0;
   logic [4:0]  rt = '0;
   logic [4:0]  shift = '0;
   logic [5:0]  func = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] wr_data;
   logic [AW-1:0] wr_addr;
   logic [2:0]  count;
   logic        wrap;

   inst_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shift(shift), .func(func),
      .out_valid(out_valid), .out_ready(out_ready),
      .wr_data(wr_data), .wr_addr(wr_addr), .count(count), .wrap(wrap)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: queue of pending words, next address, sticky wrap.
   logic [31:0] q[$];
   int          m_addr = 0;
   bit          m_wrap = 1'b0;

   function automatic logic [31:0] pack(input longint op, input longint r1, input longint r2,
                                        input longint r3, input longint sh, input longint fn);
      longint v;
      v = op * 67108864 + r1 * 2097152 + r2 * 65536 + r3 * 2048 + sh * 64 + fn;
      return 32'(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_addr = 0;
      m_wrap = 1'b0;
   endtask

   task automatic check_model();
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      if (q.size() != 0) chk("wr_data", wr_data, q[0]);
   endtask

   task automatic peek();
      @(negedge clk);
   endtask

   // One clock: check state at the falling edge, drive inputs, advance the model at the rising edge.
   task automatic step(input bit iv, input int op, input int r1, input int r2, input int r3,
                       input int sh, input int fn, input bit ordy, input bit clr);
      bit          do_push;
      bit          do_pop;
      logic [31:0] w;
      @(negedge clk);
      check_model();
      in_valid  = iv;
      opcode    = op[5:0];
      rd        = r1[4:0];
      rs        = r2[4:0];
      rt        = r3[4:0];
      shift     = sh[4:0];
      func      = fn[5:0];
      out_ready = ordy;
      clear     = clr;
      w         = pack(op, r1, r2, r3, sh, fn);
      do_push   = iv && (q.size() != DEPTH);
      do_pop    = (q.size() != 0) && ordy;
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else begin
         if (do_pop) begin
            void'(q.pop_front());
            if (m_addr == AMOD - 1) m_wrap = 1'b1;
            m_addr = (m_addr + 1) % AMOD;
         end
         if (do_push) q.push_back(w);
      end
      #1;
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic step_rand(input bit iv, input bit ordy, input bit clr);
      step(iv, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), ordy, clr);
   endtask

   task automatic step_word(input logic [31:0] w, input bit iv, input bit ordy);
      step(iv, int'(w[31:26]), int'(w[25:21]), int'(w[20:16]), int'(w[15:11]),
           int'(w[10:6]), int'(w[5:0]), ordy, 1'b0);
   endtask

   int          rt_words[5] = '{125, 132, 264, 143, 279};
   logic [31:0] bp[5];

   initial begin
      // Reset values while held in reset.
      #3;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      #10 rst_n = 1'b1;

      // First word.
      step(1'b1, 1, 2, 3, 4, 0, 32, 1'b1, 1'b0);
      peek();
      chk("first_data", wr_data, 32'h0443_2020);
      chk("first_addr", 32'(wr_addr), 32'd0);
      chk("first_valid", 32'(out_valid), 32'd1);
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      peek();
      chk("first_addr_after", 32'(wr_addr), 32'd1);
      chk("first_count_after", 32'(count), 32'd0);

      // Round trip through the field positions.
      foreach (rt_words[i]) begin
         step(1'b1, 0, 0, 0, 0, rt_words[i] / 64, rt_words[i] % 64, 1'b0, 1'b0);
         peek();
         chk("rt_word", wr_data, 32'(rt_words[i]));
         chk("rt_shift", 32'(wr_data[10:6]), 32'(rt_words[i] / 64));
         chk("rt_func", 32'(wr_data[5:0]), 32'(rt_words[i] % 64));
         step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      end

      // Back-pressure: fill to DEPTH, hold the fifth set, then drain in order.
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) bp[k] = $urandom;
      for (int k = 0; k < 4; k++) step_word(bp[k], 1'b1, 1'b0);
      peek();
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      chk("bp_count_full", 32'(count), 32'd4);
      step_word(bp[4], 1'b1, 1'b0);
      peek();
      chk("bp_count_held", 32'(count), 32'd4);
      for (int k = 0; k < 5; k++) begin
         peek();
         chk("bp_drain_addr", 32'(wr_addr), 32'(k));
         chk("bp_drain_data", wr_data, bp[k]);
         step_word(bp[4], (k < 2), 1'b1);
      end
      peek();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Address roll-over with continuous streaming.
      for (int i = 0; i < 300 && !m_wrap; i++) step_rand(1'b1, 1'b1, 1'b0);
      peek();
      chk("wrap_set", 32'(wrap), 32'd1);
      for (int i = 0; i < 5; i++) step_rand(1'b1, 1'b1, 1'b0);
      peek();
      chk("wrap_sticky", 32'(wrap), 32'd1);
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

      // Clear beats simultaneous push and pop.
      step_rand(1'b1, 1'b0, 1'b0);
      step_rand(1'b1, 1'b0, 1'b0);
      peek();
      chk("clr_pre_count", 32'(count), 32'd2);
      step_rand(1'b1, 1'b1, 1'b1);
      peek();
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_out_valid", 32'(out_valid), 32'd0);
      chk("clr_wr_addr", 32'(wr_addr), 32'd0);
      chk("clr_wrap", 32'(wrap), 32'd0);
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

      // Asynchronous reset mid-burst.
      for (int i = 0; i < 3; i++) step_rand(1'b1, 1'b0, 1'b0);
      peek();
      chk("ares_pre_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("ares_count", 32'(count), 32'd0);
      chk("ares_out_valid", 32'(out_valid), 32'd0);
      chk("ares_in_ready", 32'(in_ready), 32'd1);
      chk("ares_wr_addr", 32'(wr_addr), 32'd0);
      chk("ares_wrap", 32'(wrap), 32'd0);
      chk("ares_wr_data", wr_data, 32'd0);
      model_reset();
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 600; i++) begin
         step_rand($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      end
      peek();
      check_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
